// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel scan sequencer: state encoding and
// the channel bit-slice layout of a frame buffer word.
package led_panel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_ADDR,
      ST_LATCH,
      ST_DISPLAY
   } scan_state_e;

   // A frame buffer word is {red, green, blue}, each channel PLANES bits wide.
   localparam int CH_BLUE  = 0;
   localparam int CH_GREEN = 1;
   localparam int CH_RED   = 2;

   function automatic int chan_lsb(input int chan, input int planes);
      return chan * planes;
   endfunction

   function automatic int chan_msb(input int chan, input int planes);
      return chan * planes + planes - 1;
   endfunction

   function automatic int red_lsb(input int planes);
      return chan_lsb(CH_RED, planes);
   endfunction

   function automatic int red_msb(input int planes);
      return chan_msb(CH_RED, planes);
   endfunction

   function automatic int green_lsb(input int planes);
      return chan_lsb(CH_GREEN, planes);
   endfunction

   function automatic int green_msb(input int planes);
      return chan_msb(CH_GREEN, planes);
   endfunction

   function automatic int blue_lsb(input int planes);
      return chan_lsb(CH_BLUE, planes);
   endfunction

   function automatic int blue_msb(input int planes);
      return chan_msb(CH_BLUE, planes);
   endfunction

endpackage

// File: rtl/led_panel_scan_ctrl.sv
// Scan sequencer for one LED panel: fetches a row/bit-plane from the frame
// buffer, shifts it out, latches it, and times the BCM on-period.
module led_panel_scan_ctrl
   import led_panel_pkg::*;
#(
   parameter  int COLS    = 32,
   parameter  int ROWS    = 8,
   parameter  int PLANES  = 2,
   parameter  int ON_BASE = 8,
   localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int DW      = 3 * PLANES
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic          fb_rd_en,
   output logic [RW-1:0] fb_row,
   output logic [CW-1:0] fb_col,
   input  logic [DW-1:0] fb_rdata,
   output logic          red_out,
   output logic          green_out,
   output logic          blue_out,
   output logic          sclk_out,
   output logic          latch_out,
   output logic          blank_out,
   output logic          aclk_out,
   output logic          arst_out,
   output logic          frame_done,
   output logic          busy
);

   localparam int PW     = (PLANES > 1) ? $clog2(PLANES) : 1;
   localparam int ON_MAX = ON_BASE << (PLANES - 1);
   localparam int TW     = (ON_MAX > 1) ? $clog2(ON_MAX) : 1;

   localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

   localparam int RED_MSB   = red_msb(PLANES);
   localparam int RED_LSB   = red_lsb(PLANES);
   localparam int GREEN_MSB = green_msb(PLANES);
   localparam int GREEN_LSB = green_lsb(PLANES);
   localparam int BLUE_MSB  = blue_msb(PLANES);
   localparam int BLUE_LSB  = blue_lsb(PLANES);

   scan_state_e   state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [PW-1:0] plane_q, plane_d;
   logic [TW-1:0] timer_q, timer_d;

   logic          fb_rd_en_q, fb_rd_en_d;
   logic [RW-1:0] fb_row_q, fb_row_d;
   logic [CW-1:0] fb_col_q, fb_col_d;
   logic          red_q, red_d;
   logic          green_q, green_d;
   logic          blue_q, blue_d;
   logic          sclk_q, sclk_d;
   logic          latch_q, latch_d;
   logic          blank_q, blank_d;
   logic          aclk_q, aclk_d;
   logic          arst_q, arst_d;
   logic          frame_done_q, frame_done_d;
   logic          busy_q, busy_d;

   logic [PLANES-1:0] red_ch, green_ch, blue_ch;

   assign red_ch   = fb_rdata[RED_MSB:RED_LSB];
   assign green_ch = fb_rdata[GREEN_MSB:GREEN_LSB];
   assign blue_ch  = fb_rdata[BLUE_MSB:BLUE_LSB];

   // Next-state and counter updates.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      plane_d = plane_q;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_FETCH;
               row_d   = '0;
               plane_d = '0;
            end
         end
         ST_FETCH: begin
            col_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT:     state_d = ST_SHIFT_LO;
         ST_SHIFT_LO: state_d = ST_SHIFT_HI;
         ST_SHIFT_HI: begin
            if (col_q == COL_LAST) begin
               state_d = ST_ADDR;
            end else begin
               col_d   = col_q + CW'(1);
               state_d = ST_SHIFT_LO;
            end
         end
         ST_ADDR:  state_d = ST_LATCH;
         ST_LATCH: begin
            timer_d = TW'((ON_BASE << plane_q) - 1);
            state_d = ST_DISPLAY;
         end
         ST_DISPLAY: begin
            if (timer_q == '0) begin
               if (plane_q == PLANE_LAST) begin
                  plane_d = '0;
                  row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
               end else begin
                  plane_d = plane_q + PW'(1);
               end
               state_d = enable ? ST_FETCH : ST_IDLE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes from a flop
   // and lines up with the state it belongs to. A read issued with
   // fb_rd_en returns its word on fb_rdata the following cycle, which is
   // exactly when the decode below enters SHIFT_LO for that column.
   always_comb begin
      fb_rd_en_d   = 1'b0;
      fb_row_d     = fb_row_q;
      fb_col_d     = fb_col_q;
      red_d        = 1'b0;
      green_d      = 1'b0;
      blue_d       = 1'b0;
      sclk_d       = 1'b0;
      latch_d      = 1'b0;
      blank_d      = 1'b1;
      aclk_d       = 1'b0;
      arst_d       = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = (state_d != ST_IDLE);
      case (state_d)
         ST_FETCH: begin
            fb_rd_en_d = 1'b1;
            fb_row_d   = row_d;
            fb_col_d   = '0;
         end
         ST_SHIFT_LO: begin
            red_d   = red_ch[plane_d];
            green_d = green_ch[plane_d];
            blue_d  = blue_ch[plane_d];
            if (col_d != COL_LAST) begin
               fb_rd_en_d = 1'b1;
               fb_row_d   = row_d;
               fb_col_d   = col_d + CW'(1);
            end
         end
         ST_SHIFT_HI: begin
            sclk_d  = 1'b1;
            red_d   = red_q;
            green_d = green_q;
            blue_d  = blue_q;
         end
         ST_ADDR: begin
            // Row address only moves once per row, on its first plane.
            if (plane_d == '0) begin
               arst_d = (row_d == '0);
               aclk_d = (row_d != '0);
            end
         end
         ST_LATCH: latch_d = 1'b1;
         ST_DISPLAY: begin
            blank_d      = 1'b0;
            frame_done_d = (timer_d == '0) && (plane_d == PLANE_LAST) &&
                           (row_d == ROW_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         plane_q      <= '0;
         timer_q      <= '0;
         fb_rd_en_q   <= 1'b0;
         fb_row_q     <= '0;
         fb_col_q     <= '0;
         red_q        <= 1'b0;
         green_q      <= 1'b0;
         blue_q       <= 1'b0;
         sclk_q       <= 1'b0;
         latch_q      <= 1'b0;
         blank_q      <= 1'b1;
         aclk_q       <= 1'b0;
         arst_q       <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         plane_q      <= plane_d;
         timer_q      <= timer_d;
         fb_rd_en_q   <= fb_rd_en_d;
         fb_row_q     <= fb_row_d;
         fb_col_q     <= fb_col_d;
         red_q        <= red_d;
         green_q      <= green_d;
         blue_q       <= blue_d;
         sclk_q       <= sclk_d;
         latch_q      <= latch_d;
         blank_q      <= blank_d;
         aclk_q       <= aclk_d;
         arst_q       <= arst_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign fb_rd_en   = fb_rd_en_q;
   assign fb_row     = fb_row_q;
   assign fb_col     = fb_col_q;
   assign red_out    = red_q;
   assign green_out  = green_q;
   assign blue_out   = blue_q;
   assign sclk_out   = sclk_q;
   assign latch_out  = latch_q;
   assign blank_out  = blank_q;
   assign aclk_out   = aclk_q;
   assign arst_out   = arst_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_led_panel_scan_ctrl.sv
// Directed bench for led_panel_scan_ctrl with COLS=4, ROWS=2, PLANES=2,
// ON_BASE=2 and a synchronous-read frame buffer model.
module tb_led_panel_scan_ctrl;

   localparam int COLS    = 4;
   localparam int ROWS    = 2;
   localparam int PLANES  = 2;
   localparam int ON_BASE = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       fb_rd_en;
   logic [0:0] fb_row;
   logic [1:0] fb_col;
   logic [5:0] fb_rdata = '0;
   logic       red_out, green_out, blue_out;
   logic       sclk_out, latch_out, blank_out;
   logic       aclk_out, arst_out, frame_done, busy;

   int vectors     = 0;
   int miscompares = 0;

   int cyc_cnt  = 0;
   int fd_last  = -1;
   int fd_prev  = -1;
   int arst_cnt = 0;
   int aclk_cnt = 0;
   int sclk_cnt = 0;
   logic sclk_prev = 1'b0;

   led_panel_scan_ctrl #(
      .COLS    (COLS),
      .ROWS    (ROWS),
      .PLANES  (PLANES),
      .ON_BASE (ON_BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fb_rd_en   (fb_rd_en),
      .fb_row     (fb_row),
      .fb_col     (fb_col),
      .fb_rdata   (fb_rdata),
      .red_out    (red_out),
      .green_out  (green_out),
      .blue_out   (blue_out),
      .sclk_out   (sclk_out),
      .latch_out  (latch_out),
      .blank_out  (blank_out),
      .aclk_out   (aclk_out),
      .arst_out   (arst_out),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Pixel content: red=01 on even columns, green=11 everywhere, blue=10 on row 1.
   function automatic logic [5:0] fb_word(input logic row, input logic [1:0] col);
      logic [1:0] red;
      red = (col == 2'd0 || col == 2'd2) ? 2'b01 : 2'b00;
      return {red, 2'b11, row ? 2'b10 : 2'b00};
   endfunction

   // Synchronous-read frame buffer; outside a read response it drives noise.
   always @(posedge clk) begin
      if (fb_rd_en) fb_rdata <= fb_word(fb_row[0], fb_col);
      else          fb_rdata <= 6'($urandom);
   end

   always @(negedge clk) begin
      cyc_cnt = cyc_cnt + 1;
      if (frame_done) begin
         fd_prev = fd_last;
         fd_last = cyc_cnt;
      end
      if (arst_out) arst_cnt = arst_cnt + 1;
      if (aclk_out) aclk_cnt = aclk_cnt + 1;
      if (sclk_out && !sclk_prev) sclk_cnt = sclk_cnt + 1;
      sclk_prev = sclk_out;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] obs_vec();
      return 16'({fb_rd_en, red_out, green_out, blue_out, sclk_out, latch_out,
                  blank_out, aclk_out, arst_out, frame_done, busy});
   endfunction

   function automatic logic [15:0] pack(input logic rd, input logic r, input logic g,
                                        input logic b, input logic sclk, input logic latch,
                                        input logic blank, input logic aclk, input logic arst,
                                        input logic fd, input logic bsy);
      return 16'({rd, r, g, b, sclk, latch, blank, aclk, arst, fd, bsy});
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps through one plane starting with its FETCH cycle and checks every
   // output against the cycle schedule. drop_at clears enable after that
   // cycle; stop_k ends the walk early (-1 = run the whole plane).
   task automatic check_plane(input int row, input int plane, input int drop_at,
                              input int stop_k);
      int n, last, c;
      logic [5:0] w;
      logic e_rd, e_r, e_g, e_b, e_sclk, e_latch, e_blank, e_aclk, e_arst, e_fd;
      logic [1:0] e_col;
      n    = 4 + 2 * COLS + (ON_BASE << plane);
      last = (stop_k >= 0) ? stop_k : n - 1;
      for (int k = 0; k <= last; k++) begin
         tick();
         e_rd = 0; e_r = 0; e_g = 0; e_b = 0; e_sclk = 0; e_latch = 0;
         e_blank = 1; e_aclk = 0; e_arst = 0; e_fd = 0; e_col = 2'd0;
         if (k == 0) begin
            e_rd = 1;
         end else if (k >= 2 && k < 2 + 2 * COLS) begin
            c   = (k - 2) / 2;
            w   = fb_word(row[0], c[1:0]);
            e_r = w[4 + plane];
            e_g = w[2 + plane];
            e_b = w[plane];
            if (k % 2 == 0) begin
               if (c < COLS - 1) begin
                  e_rd  = 1;
                  e_col = 2'(c + 1);
               end
            end else begin
               e_sclk = 1;
            end
         end else if (k == 2 + 2 * COLS) begin
            e_arst = (plane == 0 && row == 0);
            e_aclk = (plane == 0 && row != 0);
         end else if (k == 3 + 2 * COLS) begin
            e_latch = 1;
         end else if (k >= 4 + 2 * COLS) begin
            e_blank = 0;
            e_fd    = (k == n - 1 && row == ROWS - 1 && plane == PLANES - 1);
         end
         check($sformatf("r%0d p%0d k%0d pins", row, plane, k), obs_vec(),
               pack(e_rd, e_r, e_g, e_b, e_sclk, e_latch, e_blank, e_aclk, e_arst, e_fd, 1'b1));
         if (e_rd)
            check($sformatf("r%0d p%0d k%0d fb_addr", row, plane, k),
                  16'({fb_row, fb_col}), 16'({row[0], e_col}));
         if (k == drop_at) enable = 1'b0;
      end
   endtask

   initial begin
      int s0, a0, k0;
      reset  = 1'b0;
      enable = 1'b0;

      // Asynchronous reset before the first clock edge.
      #3 reset = 1'b1;
      #1;
      check("reset pins", obs_vec(),
            pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      check("reset fb_addr", 16'({fb_row, fb_col}), 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      tick();
      check("idle pins", obs_vec(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      enable = 1'b1;

      // Two full frames.
      s0 = sclk_cnt;
      a0 = arst_cnt;
      k0 = aclk_cnt;
      check_plane(0, 0, -1, -1);
      @(negedge clk); #1;
      check("sclk rises row0 plane0", 16'(sclk_cnt - s0), 16'd4);
      for (int f = 0; f < 2; f++) begin
         if (f != 0) check_plane(0, 0, -1, -1);
         check_plane(0, 1, -1, -1);
         check_plane(1, 0, -1, -1);
         check_plane(1, 1, -1, -1);
      end
      @(negedge clk); #1;
      check("arst pulses 2 frames", 16'(arst_cnt - a0), 16'd2);
      check("aclk pulses 2 frames", 16'(aclk_cnt - k0), 16'd2);
      check("frame_done period", 16'(fd_last - fd_prev), 16'd60);

      // Enable dropped mid-shift: plane completes, then idle.
      check_plane(0, 0, 4, -1);
      tick();
      check("idle after drop", obs_vec(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tick();
      check("idle hold", obs_vec(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      enable = 1'b1;
      check_plane(0, 0, -1, -1);
      check_plane(0, 1, -1, -1);
      check_plane(1, 0, -1, -1);

      // Reset in the first DISPLAY cycle of row 1 plane 1.
      check_plane(1, 1, -1, 4 + 2 * COLS);
      #2 reset = 1'b1;
      #1;
      check("reset mid display", obs_vec(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tick();
      check("reset held", obs_vec(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      reset = 1'b0;
      check_plane(0, 0, -1, -1);
      check_plane(0, 1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
